// File: rtl/resultado_display7seg.sv
// Two-digit multiplexed 7-segment driver for the 5-bit adder result.
// Captures the input once per scan frame and converts it to BCD with a serial double-dabble.
module resultado_display7seg #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk_100M,
    input  logic       rst_n,
    input  logic [3:0] c,
    input  logic       carry_out,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       dp
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);

    typedef enum logic [0:0] {StIdle, StConv} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sel_q, sel_d;
    logic            start_pend_q, start_pend_d;
    logic [4:0]      shreg_q, shreg_d;
    logic [7:0]      bcd_q, bcd_d;
    logic [2:0]      it_q, it_d;
    logic [3:0]      tens_q, tens_d;
    logic [3:0]      units_q, units_d;
    logic            valid_q, valid_d;
    logic [6:0]      seg_d;
    logic [1:0]      an_d;
    logic            cnt_wrap;
    logic            frame_wrap;
    logic [7:0]      bcd_adj;
    logic [7:0]      bcd_shift;

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign dp = 1'b1;

    always_comb begin
        cnt_wrap   = (cnt_q == CntLast);
        frame_wrap = cnt_wrap && sel_q;
        cnt_d      = cnt_wrap ? '0 : cnt_q + CntW'(1);
        sel_d      = cnt_wrap ? ~sel_q : sel_q;
    end

    // Double-dabble step: correct nibbles >= 5, then shift in the next binary bit.
    always_comb begin
        bcd_adj[7:4] = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
        bcd_adj[3:0] = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
        bcd_shift    = 8'({bcd_adj, shreg_q[4]});
    end

    always_comb begin
        state_d      = state_q;
        start_pend_d = start_pend_q;
        shreg_d      = shreg_q;
        bcd_d        = bcd_q;
        it_d         = it_q;
        tens_d       = tens_q;
        units_d      = units_q;
        valid_d      = valid_q;
        unique case (state_q)
            StIdle: begin
                if (start_pend_q) begin
                    shreg_d      = {carry_out, c};
                    bcd_d        = '0;
                    it_d         = '0;
                    start_pend_d = 1'b0;
                    state_d      = StConv;
                end
            end
            StConv: begin
                bcd_d   = bcd_shift;
                shreg_d = {shreg_q[3:0], 1'b0};
                it_d    = it_q + 3'd1;
                if (it_q == 3'd4) begin
                    tens_d  = bcd_shift[7:4];
                    units_d = bcd_shift[3:0];
                    valid_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // A frame request arriving mid-conversion stays pending until the FSM is idle.
        if (frame_wrap) start_pend_d = 1'b1;
    end

    always_comb begin
        an_d  = 2'b11;
        seg_d = 7'h7F;
        if (valid_q) begin
            if (!sel_q) begin
                an_d  = 2'b10;
                seg_d = enc(units_q);
            end else if (tens_q != 4'd0) begin
                an_d  = 2'b01;
                seg_d = enc(tens_q);
            end
        end
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            sel_q        <= 1'b0;
            start_pend_q <= 1'b1;
            shreg_q      <= '0;
            bcd_q        <= '0;
            it_q         <= '0;
            tens_q       <= '0;
            units_q      <= '0;
            valid_q      <= 1'b0;
            an           <= 2'b11;
            seg          <= 7'h7F;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            start_pend_q <= start_pend_d;
            shreg_q      <= shreg_d;
            bcd_q        <= bcd_d;
            it_q         <= it_d;
            tens_q       <= tens_d;
            units_q      <= units_d;
            valid_q      <= valid_d;
            an           <= an_d;
            seg          <= seg_d;
        end
    end

endmodule
